// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, FSM state encoding and result clamp for the 5x5 convolution core
package conv_pkg;
  localparam int PIX_W = 16;
  localparam int KSIZE = 5;
  localparam int PACK = 8;
  localparam int ACC_W = 40;
  localparam int NTAP = KSIZE * KSIZE;
  localparam int PROD_W = 2 * PIX_W + 1;
  typedef enum logic [2:0] {IDLE, LOAD_COEF, FILL, RUN, FLUSH} state_t;
  function automatic logic [PIX_W-1:0] clamp(input logic [ACC_W-1:0] v);
    return v[ACC_W-1] ? '0 : |v[ACC_W-2:PIX_W] ? '1 : v[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/conv5x5_dot.sv
// conv5x5_dot: registered 25-tap signed products, summed and clamped for the pack lane write
module conv5x5_dot
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [NTAP*PIX_W-1:0] coef,
  input  logic [NTAP*PIX_W-1:0] pix,
  output logic                  out_valid,
  output logic [PIX_W-1:0]      out_data
);
  logic signed [PROD_W-1:0] prod [NTAP];
  logic [ACC_W-1:0] acc;
  always_ff @(posedge clk) begin
    out_valid <= clear ? 1'b0 : in_valid;
    for (int i = 0; i < NTAP; i++)
      prod[i] <= $signed({1'b0, pix[i*PIX_W +: PIX_W]}) * $signed(coef[i*PIX_W +: PIX_W]);
  end
  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAP; i++)
      acc = acc + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
  end
  assign out_data = clamp(acc);
endmodule

// File: rtl/conv5x5_core.sv
// conv5x5_core: 5x5 sliding-window convolution with 8-lane result packing and stripe/frame control
module conv5x5_core
  import conv_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   coef_valid,
  input  logic [KSIZE*PIX_W-1:0] coef_data,
  input  logic                   col_valid,
  output logic                   col_ready,
  input  logic [KSIZE*PIX_W-1:0] col_data,
  input  logic                   col_last,
  input  logic                   col_eof,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [PACK*PIX_W-1:0]  res_data,
  output logic [3:0]             res_cnt,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  state_t state;
  logic [NTAP*PIX_W-1:0] coef, win;
  logic [PACK*PIX_W-1:0] pack, pack_nx;
  logic [2:0] coef_idx, col_cnt;
  logic [3:0] lane_cnt, cnt_nx;
  logic [PIX_W-1:0] dot_data;
  logic issue, eof_q, final_q, dot_valid, accept, last, full, flush_rdy, out_free, emit, flush_exit, short_run;
  conv5x5_dot dot (
    .clk(clk),
    .clear(reset || start),
    .in_valid(issue),
    .coef(coef),
    .pix(win),
    .out_valid(dot_valid),
    .out_data(dot_data)
  );
  assign col_ready = (state == FILL || state == RUN) && !res_valid;
  assign busy = state != IDLE;
  assign accept = col_valid && col_ready;
  assign last = col_last || col_eof;
  assign short_run = last && col_cnt == 3'd4;
  assign cnt_nx = lane_cnt + {3'd0, dot_valid};
  assign full = cnt_nx == 4'(PACK);
  assign flush_rdy = state == FLUSH && !issue;
  assign out_free = !res_valid || res_ready;
  assign emit = full || (flush_rdy && cnt_nx != 4'd0 && out_free);
  assign flush_exit = flush_rdy && (full || out_free);
  always_comb begin
    pack_nx = pack;
    if (dot_valid) pack_nx[lane_cnt[2:0]*PIX_W +: PIX_W] = dot_data;
  end
  always_ff @(posedge clk) begin
    if (reset || start) begin
      state <= reset ? IDLE : LOAD_COEF;
      coef_idx <= '0;
      col_cnt <= '0;
      lane_cnt <= '0;
      pack <= '0;
      issue <= 1'b0;
      eof_q <= 1'b0;
      final_q <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_cnt <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      issue <= 1'b0;
      done <= res_valid && res_ready && final_q;
      final_q <= (res_valid && res_ready) ? 1'b0 : final_q;
      pack <= emit ? '0 : pack_nx;
      lane_cnt <= emit ? 4'd0 : cnt_nx;
      if (emit) begin
        res_valid <= 1'b1;
        res_data <= pack_nx;
        res_cnt <= cnt_nx;
      end else if (res_ready) begin
        res_valid <= 1'b0;
        res_cnt <= '0;
      end
      if (accept) win <= {col_data, win[NTAP*PIX_W-1:KSIZE*PIX_W]};
      case (state)
        LOAD_COEF: if (coef_valid) begin
          coef[coef_idx*KSIZE*PIX_W +: KSIZE*PIX_W] <= coef_data;
          coef_idx <= coef_idx + 3'd1;
          if (coef_idx == 3'd4) state <= FILL;
        end
        FILL: if (accept) begin
          col_cnt <= last ? 3'd0 : col_cnt + 3'd1;
          if (last) begin
            err <= 1'b1;
            state <= col_eof ? IDLE : FILL;
          end else if (col_cnt == 3'd3) state <= RUN;
        end
        RUN: if (accept) begin
          col_cnt <= last ? 3'd0 : 3'd5;
          issue <= !short_run;
          if (short_run) err <= 1'b1;
          if (last) begin
            eof_q <= col_eof;
            state <= short_run ? (col_eof ? IDLE : FILL) : FLUSH;
          end
        end
        FLUSH: if (flush_exit) begin
          state <= eof_q ? IDLE : FILL;
          final_q <= eof_q;
        end
        default: ;
      endcase
    end
  end
endmodule
